// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the floating-point pre-alignment pipeline:
//   - default field widths (exponent, stored fraction, shift amount)
//   - bit positions inside the 5-bit exception vector
//   - per-operand classification flags produced by fp_classify
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int DEF_SH_W  = 5;

  // Exception vector layout: {any, aNaN, bNaN, aInf, bInf}
  localparam int EXC_W    = 5;
  localparam int EXC_ANY  = 4;
  localparam int EXC_ANAN = 3;
  localparam int EXC_BNAN = 2;
  localparam int EXC_AINF = 1;
  localparam int EXC_BINF = 0;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fp_class_t;

endpackage

// File: rtl/fp_prealign_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_prealign_pipe_if
// Handshake + data bundle for fp_prealign_pipe.
//   Input side : in_valid, in_ready, a, b, op (0=add, 1=sub)
//   Output side: out_valid, out_ready, sign_l, eff_sub, swap, exp_l,
//                man_l, man_s, shift, exc, zero_a, zero_b, exc_cnt
// Modports: slave = the pipeline, master = whoever feeds and drains it.
// -----------------------------------------------------------------------------
interface fp_prealign_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int SH_W  = DEF_SH_W
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             op;

  logic             out_valid;
  logic             out_ready;
  logic             sign_l;
  logic             eff_sub;
  logic             swap;
  logic [EXP_W-1:0] exp_l;
  logic [MAN_W:0]   man_l;
  logic [MAN_W:0]   man_s;
  logic [SH_W-1:0]  shift;
  logic [EXC_W-1:0] exc;
  logic             zero_a;
  logic             zero_b;
  logic [15:0]      exc_cnt;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sign_l, eff_sub, swap, exp_l,
           man_l, man_s, shift, exc, zero_a, zero_b, exc_cnt
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sign_l, eff_sub, swap, exp_l,
           man_l, man_s, shift, exc, zero_a, zero_b, exc_cnt
  );

endinterface

// File: rtl/fp_classify.sv
// -----------------------------------------------------------------------------
// fp_classify
// Combinational decode of one IEEE-style operand.
//   x       : packed operand {sign, exponent, fraction}
//   sign    : sign bit
//   exp_eff : effective biased exponent used for ordering/shift
//   man     : significand with hidden bit
//   cls     : NaN / Inf / zero flags
// Build option FP_PREALIGN_DENORM_EN: when defined, denormals keep their
// fraction with exponent 1 and hidden bit 0; otherwise they flush to a
// signed zero (zero flag set, exponent and significand 0).
// -----------------------------------------------------------------------------
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp_eff,
  output logic [MAN_W:0]       man,
  output fp_class_t            cls
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;
  logic             e_ones;
  logic             f_zero;

  assign sign   = x[EXP_W+MAN_W];
  assign e      = x[EXP_W+MAN_W-1:MAN_W];
  assign f      = x[MAN_W-1:0];
  assign e_ones = &e;
  assign f_zero = ~|f;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    cls.nan  = e_ones & ~f_zero;
    cls.inf  = e_ones &  f_zero;
    cls.zero = 1'b0;
    exp_eff  = e;
    man      = {1'b1, f};
    if (~|e) begin
`ifdef FP_PREALIGN_DENORM_EN
      // True zero stays at exponent 0; a denormal sits at exponent 1
      // with no hidden bit, which makes it directly comparable to normals.
      cls.zero = f_zero;
      exp_eff  = f_zero ? '0 : EXP_W'(1);
      man      = {1'b0, f};
`else
      cls.zero = 1'b1;
      exp_eff  = '0;
      man      = '0;
`endif
    end
  end

endmodule

// File: rtl/fp_prealign_pipe.sv
// -----------------------------------------------------------------------------
// fp_prealign_pipe
// Two-stage pre-alignment front end of an FP adder.
//   S1 (classify): decode both operands, register them together with both
//                  exponent differences computed at EXP_W+1 bits.
//   S2 (order/shift): pick the larger magnitude, produce the saturated
//                  alignment shift and exception flags, hold while stalled.
// Ports: clk, rst_n (async, active-low), bus (fp_prealign_pipe_if.slave).
// exc_cnt counts exceptional results as they leave S2 (saturating).
// Build option FP_PREALIGN_DENORM_EN selects denormal handling (fp_classify).
// -----------------------------------------------------------------------------
module fp_prealign_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int SH_W  = DEF_SH_W
) (
  input logic               clk,
  input logic               rst_n,
  fp_prealign_pipe_if.slave bus
);

  localparam int DW = EXP_W + 1;
  localparam logic [DW-1:0] SHIFT_MAX = DW'(MAN_W + 3);

  // Operand decode
  logic             sa_c, sb_c;
  logic [EXP_W-1:0] ea_c, eb_c;
  logic [MAN_W:0]   ma_c, mb_c;
  fp_class_t        ca_c, cb_c;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x(bus.a), .sign(sa_c), .exp_eff(ea_c), .man(ma_c), .cls(ca_c)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x(bus.b), .sign(sb_c), .exp_eff(eb_c), .man(mb_c), .cls(cb_c)
  );

  // Stage 1 registers
  logic             s1_valid;
  logic             s1_op, s1_sa, s1_sb;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W:0]   s1_ma, s1_mb;
  fp_class_t        s1_ca, s1_cb;
  logic [DW-1:0]    s1_dab, s1_dba;

  // S2 may take a new result when it is empty or its result leaves this cycle.
  logic s2_advance;
  assign s2_advance   = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = ~s1_valid | s2_advance;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared as well as the valid bit, so a
      // reset pipeline shows all-zero contents rather than stale operands.
      s1_valid <= 1'b0;
      s1_op    <= 1'b0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
      s1_ea    <= '0;
      s1_eb    <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s1_ca    <= '0;
      s1_cb    <= '0;
      s1_dab   <= '0;
      s1_dba   <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op  <= bus.op;
        s1_sa  <= sa_c;
        s1_sb  <= sb_c;
        s1_ea  <= ea_c;
        s1_eb  <= eb_c;
        s1_ma  <= ma_c;
        s1_mb  <= mb_c;
        s1_ca  <= ca_c;
        s1_cb  <= cb_c;
        // One extra bit so the full exponent range cannot wrap.
        s1_dab <= {1'b0, ea_c} - {1'b0, eb_c};
        s1_dba <= {1'b0, eb_c} - {1'b0, ea_c};
      end
    end
  end

  // Stage 2 combinational ordering
  logic             swap_c;
  logic [DW-1:0]    dist_c;
  logic [SH_W-1:0]  shift_c;
  logic [EXC_W-1:0] exc_c;

  always_comb begin
    // Exponent is the more significant field, so one wide compare orders
    // by exponent first and fraction second; equality leaves swap at 0.
    swap_c  = {s1_eb, s1_mb} > {s1_ea, s1_ma};
    // The difference taken as larger-minus-smaller is never negative.
    dist_c  = swap_c ? s1_dba : s1_dab;
    shift_c = (dist_c > SHIFT_MAX) ? SH_W'(SHIFT_MAX) : SH_W'(dist_c);
    exc_c           = '0;
    exc_c[EXC_ANAN] = s1_ca.nan;
    exc_c[EXC_BNAN] = s1_cb.nan;
    exc_c[EXC_AINF] = s1_ca.inf;
    exc_c[EXC_BINF] = s1_cb.inf;
    exc_c[EXC_ANY]  = s1_ca.nan | s1_cb.nan | s1_ca.inf | s1_cb.inf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.sign_l    <= 1'b0;
      bus.eff_sub   <= 1'b0;
      bus.swap      <= 1'b0;
      bus.exp_l     <= '0;
      bus.man_l     <= '0;
      bus.man_s     <= '0;
      bus.shift     <= '0;
      bus.exc       <= '0;
      bus.zero_a    <= 1'b0;
      bus.zero_b    <= 1'b0;
      bus.exc_cnt   <= '0;
    end else begin
      if (s2_advance) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.swap    <= swap_c;
          // A subtracted b contributes with its sign flipped.
          bus.sign_l  <= swap_c ? (s1_sb ^ s1_op) : s1_sa;
          bus.eff_sub <= s1_op ^ s1_sa ^ s1_sb;
          bus.exp_l   <= swap_c ? s1_eb : s1_ea;
          bus.man_l   <= swap_c ? s1_mb : s1_ma;
          bus.man_s   <= swap_c ? s1_ma : s1_mb;
          bus.shift   <= shift_c;
          bus.exc     <= exc_c;
          bus.zero_a  <= s1_ca.zero;
          bus.zero_b  <= s1_cb.zero;
        end
      end
      if (bus.out_valid && bus.out_ready && bus.exc[EXC_ANY] && !(&bus.exc_cnt)) begin
        bus.exc_cnt <= bus.exc_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fp_prealign_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_prealign_pipe
// Self-checking bench for fp_prealign_pipe (default 32-bit format).
// Expected results come from an arithmetic model of the operand rules; a
// queue of expected results is compared against every cycle out_valid is
// high, so stalled outputs must keep matching the head entry.
// -----------------------------------------------------------------------------
module tb_fp_prealign_pipe;

`ifdef FP_PREALIGN_DENORM_EN
  localparam bit DENORM_EN = 1'b1;
`else
  localparam bit DENORM_EN = 1'b0;
`endif

  typedef struct packed {
    logic        sign_l;
    logic        eff_sub;
    logic        swap;
    logic [7:0]  exp_l;
    logic [23:0] man_l;
    logic [23:0] man_s;
    logic [4:0]  shift;
    logic [4:0]  exc;
    logic        zero_a;
    logic        zero_b;
  } res_t;

  logic clk;
  logic rst_n;

  fp_prealign_pipe_if #(.EXP_W(8), .MAN_W(23), .SH_W(5)) bus ();

  fp_prealign_pipe #(.EXP_W(8), .MAN_W(23), .SH_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void decode(input logic [31:0] x, output int e_eff, output int m,
                                 output bit nan, output bit inf, output bit zero);
    int e;
    int f;
    e    = int'(x[30:23]);
    f    = int'(x[22:0]);
    nan  = (e == 255) && (f != 0);
    inf  = (e == 255) && (f == 0);
    zero = 1'b0;
    if (e == 0) begin
      if (f == 0) begin
        zero = 1'b1; e_eff = 0; m = 0;
      end else if (DENORM_EN) begin
        e_eff = 1; m = f;
      end else begin
        zero = 1'b1; e_eff = 0; m = 0;
      end
    end else begin
      e_eff = e;
      m     = f + (1 << 23);
    end
  endfunction

  function automatic res_t model(input logic [31:0] xa, input logic [31:0] xb, input logic xop);
    res_t r;
    int ea, eb, ma, mb, d;
    bit na, nb, ia, ib, za, zb, sw;
    decode(xa, ea, ma, na, ia, za);
    decode(xb, eb, mb, nb, ib, zb);
    sw = (longint'(eb) * 64'd16777216 + longint'(mb)) > (longint'(ea) * 64'd16777216 + longint'(ma));
    d  = (ea > eb) ? ea - eb : eb - ea;
    r.sign_l  = sw ? (xb[31] ^ xop) : xa[31];
    r.eff_sub = xop ^ xa[31] ^ xb[31];
    r.swap    = sw;
    r.exp_l   = 8'(sw ? eb : ea);
    r.man_l   = 24'(sw ? mb : ma);
    r.man_s   = 24'(sw ? ma : mb);
    r.shift   = 5'((d > 26) ? 26 : d);
    r.exc     = {na | nb | ia | ib, na, nb, ia, ib};
    r.zero_a  = za;
    r.zero_b  = zb;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'h01;
      3:       e = 8'hFE;
      default: e = 8'($urandom_range(0, 255));
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  res_t        exp_q[$];
  res_t        obs;
  logic [15:0] model_cnt = 16'd0;
  int          delivered = 0;

  assign obs = {bus.sign_l, bus.eff_sub, bus.swap, bus.exp_l, bus.man_l, bus.man_s,
                bus.shift, bus.exc, bus.zero_a, bus.zero_b};

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 1'b0);
        end else begin
          check("result", obs, exp_q[0]);
          check("exc_cnt", bus.exc_cnt, model_cnt);
          if (bus.out_ready) begin
            if (exp_q[0].exc[4] && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.op));
    end
  end

  // ---------------- out_ready driver ----------------
  bit rand_mode    = 1'b0;
  bit forced_ready = 1'b1;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xop, output int waited);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.a = xa;
    bus.b = xb;
    bus.op = xop;
    @(negedge clk);
    while (!bus.in_ready && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    waited = guard;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 50);
    if (!bus.out_valid) check("out_valid_timeout", bus.out_valid, 1'b1);
  endtask

  // One isolated transaction with out_ready held high.
  task automatic run_one(input logic [31:0] xa, input logic [31:0] xb, input logic xop,
                         output res_t got, output logic [15:0] cnt_at,
                         output logic [15:0] cnt_after, output int lat);
    int w;
    send(xa, xb, xop, w);
    wait_out(lat);
    got    = obs;
    cnt_at = bus.exc_cnt;
    @(negedge clk);
    cnt_after = bus.exc_cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    res_t        r;
    logic [15:0] c0, c1;
    int          lat, w, total, d0;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.op       = 1'b0;

    #1;
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_exc_cnt", bus.exc_cnt, 16'd0);
    check("reset_data", obs, '0);

    #22;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 1.0 + 2.0: b is larger by one binade.
    run_one(32'h3F800000, 32'h40000000, 1'b0, r, c0, c1, lat);
    check("d1_latency", lat, 2);
    check("d1_swap", r.swap, 1'b1);
    check("d1_exp_l", r.exp_l, 8'h80);
    check("d1_shift", r.shift, 5'd1);
    check("d1_man_l", r.man_l, 24'h800000);
    check("d1_man_s", r.man_s, 24'h800000);
    check("d1_eff_sub", r.eff_sub, 1'b0);

    // +Inf vs quiet NaN.
    run_one(32'h7F800000, 32'h7FC00000, 1'b0, r, c0, c1, lat);
    check("d2_exc", r.exc, 5'b10110);
    check("d2_cnt_before", c0, 16'd0);
    check("d2_cnt_after", c1, 16'd1);

    // Largest vs smallest normal exponent: shift saturates.
    run_one(32'h7F000000, 32'h00800000, 1'b0, r, c0, c1, lat);
    check("d3_shift_sat", r.shift, 5'd26);
    check("d3_swap", r.swap, 1'b0);

    // 1.0 vs smallest denormal.
    run_one(32'h3F800000, 32'h00000001, 1'b0, r, c0, c1, lat);
    check("d4_shift", r.shift, 5'd26);
    if (DENORM_EN) begin
      check("d4_man_s", r.man_s, 24'h000001);
      check("d4_zero_b", r.zero_b, 1'b0);
    end else begin
      check("d4_man_s", r.man_s, 24'h000000);
      check("d4_zero_b", r.zero_b, 1'b1);
    end

    // Equal magnitudes, opposite signs, subtract: no swap, effective add.
    run_one(32'h40490FDB, 32'hC0490FDB, 1'b1, r, c0, c1, lat);
    check("d5_swap", r.swap, 1'b0);
    check("d5_shift", r.shift, 5'd0);
    check("d5_eff_sub", r.eff_sub, 1'b0);
    check("d5_sign_l", r.sign_l, 1'b0);

    // Three back-to-back inputs while the output is stalled.
    forced_ready = 1'b0;
    @(posedge clk);
    #3;
    d0 = delivered;
    send(32'h3F800000, 32'h3F000000, 1'b0, w);
    send(32'hC1200000, 32'h41200000, 1'b1, w);
    fork
      send(32'h7F800000, 32'hFF800000, 1'b1, w);
      begin
        @(negedge clk);
        check("b2b_in_ready_low", bus.in_ready, 1'b0);
        check("b2b_out_valid", bus.out_valid, 1'b1);
        repeat (2) @(negedge clk);
        forced_ready = 1'b1;
      end
    join
    wait_drain();
    check("b2b_delivered", delivered - d0, 3);

    // Full pipeline with out_ready high must take one input per cycle.
    total = 0;
    for (int i = 0; i < 8; i++) begin
      send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), w);
      total += w;
    end
    check("throughput_stalls", total, 0);
    wait_drain();

    // Reset while a result is stalled at the output.
    forced_ready = 1'b0;
    @(posedge clk);
    #3;
    send(32'h7F800000, 32'h3F800000, 1'b0, w);
    wait_out(lat);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_exc_cnt", bus.exc_cnt, 16'd0);
    check("rst_data", obs, '0);
    exp_q.delete();
    model_cnt    = 16'd0;
    forced_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", bus.in_ready, 1'b1);
    check("rst_release_out_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Randomised traffic with random back-pressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] xa;
      logic [31:0] xb;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        xa = rand_op();
        xb = ($urandom_range(0, 4) == 0) ? {1'($urandom_range(0, 1)), xa[30:0]} : rand_op();
        send(xa, xb, 1'($urandom_range(0, 1)), w);
      end
    end
    rand_mode    = 1'b0;
    forced_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_prealign_pipe.md
FP_PREALIGN_PIPE -- requirements
Module: fp_prealign_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent width.
REQ-002 Parameter MAN_W, default 23, stored-fraction width; operand width W = 1+EXP_W+MAN_W.
REQ-003 Parameter SH_W, default 5, shift-amount width; must hold MAN_W+3.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 in_valid / in_ready  in/out  1  input handshake.
REQ-008 a, b  in  W  IEEE-style operands; op  in  1  0=add, 1=sub.
REQ-009 out_valid / out_ready  out/in  1  output handshake.
REQ-010 sign_l  out  1  sign of larger-magnitude operand, op-adjusted when it is b.
REQ-011 eff_sub  out  1  op ^ a[W-1] ^ b[W-1].
REQ-012 swap  out  1  high when |b| > |a|.
REQ-013 exp_l  out  EXP_W  biased exponent of larger operand.
REQ-014 man_l, man_s  out  MAN_W+1  larger/smaller significand with hidden bit.
REQ-015 shift  out  SH_W  alignment shift for man_s.
REQ-016 exc  out  5  {any, aNaN, bNaN, aInf, bInf}; zero_a, zero_b  out  1 each.
REQ-017 exc_cnt  out  16  count of accepted pairs with exc[4]=1.

Function
REQ-018 Two registered stages (S1 classify, S2 order/shift); latency exactly 2 cycles from the accepting edge when out_ready=1.
REQ-019 Transfer occurs on the edge where valid&ready are both 1; each stage advances when empty or downstream accepts.
REQ-020 in_ready = ~s1_valid | s2_advance; s2 holds while out_valid & ~out_ready.
REQ-021 While out_valid=1 & out_ready=0, all outputs remain bit-stable; no data lost, order preserved.
REQ-022 S1 classification: NaN = exp all-ones & frac≠0; Inf = exp all-ones & frac=0; zero = exp=0 & frac=0; denormal = exp=0 & frac≠0.
REQ-023 S1 computes exponent differences at EXP_W+1 bits (no 5-bit truncation).
REQ-024 Magnitude compare: exponent first, then fraction; equal magnitudes give swap=0.
REQ-025 shift = min(|exp_a−exp_b|, MAN_W+3); saturation at 26 for defaults.
REQ-026 exc_cnt increments by 1 per accepted exceptional pair at S2 output transfer; saturates at 16'hFFFF.
REQ-027 Simultaneous output accept and input accept in the full state sustains one result per cycle.

Reset
REQ-028 rst_n=0 immediately clears s1_valid, out_valid, exc_cnt and all data/flag registers to 0; in-flight operations are discarded.
REQ-029 in_ready is 1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro FP_PREALIGN_DENORM_EN defined: denormals use effective exponent 1, hidden bit 0, fraction kept.
REQ-031 Macro undefined: denormals are flushed to signed zero (zero flag set, significand 0, exponent 0).

Structure
REQ-032 Shared package fp_pkg holds default EXP_W/MAN_W, exception-vector bit indices and a classification struct.
REQ-033 One sub-module fp_classify (combinational, per operand) instanced twice in S1.

Verification
REQ-034 a=0x3F800000, b=0x40000000, op=0 -> 2 cycles later: swap=1, exp_l=0x80, shift=1, man_l=man_s=0x800000, eff_sub=0.
REQ-035 a=0x7F800000, b=0x7FC00000 -> exc=5'b10110, exc_cnt increments from 0 to 1.
REQ-036 a=0x7F000000, b=0x00800000 -> shift=26 (saturated), swap=0.
REQ-037 a=0x3F800000, b=0x00000001 -> with EN: man_s=0x000001, shift=26; without: zero_b=1, man_s=0.
REQ-038 Three back-to-back inputs, out_ready low 3 cycles -> in_ready falls after pipeline fills, outputs stable, all three delivered in order.
REQ-039 rst_n pulsed low while out_valid=1 -> out_valid and exc_cnt 0 before next clock edge.
